// File: rtl/scaler_h.sv
// Horizontal cubic scaler: ping-pong line buffer, 4-tap Catmull-Rom resampler.
// Define SCALER_H_EDGE_MIRROR_EN to mirror out-of-range taps instead of clamping.
module scaler_h #(
    parameter int WIDTH             = 12,
    parameter int MAX_LINE_SIZE     = 1024,
    parameter int TABLE_INPUT_WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      horizontal_scale_step,
    input  logic [15:0]      horizontal_in_line_size,
    input  logic [15:0]      horizontal_out_line_size,
    input  logic [WIDTH-1:0] d_in,
    input  logic             dv_in,
    input  logic             hs_in,
    input  logic             vs_in,
    output logic [WIDTH-1:0] d_out,
    output logic             dv_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic             overflow
);
    localparam int AW = $clog2(MAX_LINE_SIZE);
    localparam int MW = WIDTH + 10;
    localparam int SW = MW + 2;
    localparam logic [9:0] DX_MASK = ~((10'd1 << (10 - TABLE_INPUT_WIDTH)) - 10'd1);

    typedef enum logic [2:0] {IDLE, LINE_START, TAP0, TAP1, TAP2, TAP3} state_t;

    logic [WIDTH-1:0] mem [2*MAX_LINE_SIZE];
    logic [WIDTH-1:0] rd_data;
    logic [AW-1:0]    rd_addr;

    state_t      state;
    logic        wr_sel, wr_sel_n, rd_sel, frame_first, line_vs;
    logic [15:0] wr_cntr, wr_addr, n;
    logic [1:0]  ready;
    logic [27:0] pos;
    logic [9:0]  dx_r;
    logic        wr_en, frame_restart;

    always_comb begin
        wr_sel_n = wr_sel;
        wr_addr  = wr_cntr;
        if (vs_in) begin
            wr_sel_n = 1'b0;
            wr_addr  = '0;
        end else if (hs_in) begin
            wr_sel_n = ~wr_sel;
            wr_addr  = '0;
        end
    end

    assign wr_en         = dv_in && (wr_addr < 16'(MAX_LINE_SIZE));
    assign frame_restart = dv_in && vs_in;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_sel_n, wr_addr[AW-1:0]}] <= d_in;
        rd_data <= mem[{rd_sel, rd_addr}];
    end

    // Tap index for the current read cycle, with edge handling
    logic [1:0]         tap;
    logic signed [17:0] idx, nsz, mir;
    logic [15:0]        tap_idx;

    always_comb begin
        tap = 2'd0;
        unique case (state)
            TAP1:    tap = 2'd1;
            TAP2:    tap = 2'd2;
            TAP3:    tap = 2'd3;
            default: tap = 2'd0;
        endcase
        idx = $signed({2'b00, pos[27:12]}) + $signed({16'd0, tap}) - 18'sd1;
        nsz = $signed({2'b00, horizontal_in_line_size});
`ifdef SCALER_H_EDGE_MIRROR_EN
        mir = idx;
        if (idx < 0)
            mir = -idx;
        else if (idx > nsz)
            mir = (nsz <<< 1) - idx;
`else
        mir = idx;
`endif
        if (mir < 0)
            tap_idx = '0;
        else if (mir > nsz)
            tap_idx = horizontal_in_line_size;
        else
            tap_idx = mir[15:0];
        if (tap_idx > 16'(MAX_LINE_SIZE - 1))
            rd_addr = AW'(MAX_LINE_SIZE - 1);
        else
            rd_addr = tap_idx[AW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_sel      <= 1'b0;
            wr_cntr     <= '0;
            ready       <= 2'b00;
            rd_sel      <= 1'b0;
            overflow    <= 1'b0;
            frame_first <= 1'b1;
            line_vs     <= 1'b0;
            pos         <= '0;
            n           <= '0;
            dx_r        <= '0;
        end else begin
            if (dv_in) begin
                wr_sel  <= wr_sel_n;
                wr_cntr <= wr_addr + 16'd1;
                if (hs_in && !vs_in && ready[wr_sel_n])
                    overflow <= 1'b1;
            end
            unique case (state)
                IDLE: if (ready[rd_sel]) state <= LINE_START;
                LINE_START: begin
                    pos         <= '0;
                    n           <= '0;
                    line_vs     <= frame_first;
                    frame_first <= 1'b0;
                    state       <= TAP0;
                end
                TAP0: begin
                    dx_r  <= pos[11:2] & DX_MASK;
                    state <= TAP1;
                end
                TAP1: state <= TAP2;
                TAP2: state <= TAP3;
                TAP3: begin
                    if (n == horizontal_out_line_size) begin
                        ready[rd_sel] <= 1'b0;
                        rd_sel        <= ~rd_sel;
                        state         <= IDLE;
                    end else begin
                        n     <= n + 16'd1;
                        pos   <= pos + {12'd0, horizontal_scale_step};
                        state <= TAP0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (frame_restart) begin
                ready       <= 2'b00;
                state       <= IDLE;
                rd_sel      <= 1'b0;
                frame_first <= 1'b1;
            end
            // A line completing on the release cycle stays ready
            if (dv_in && wr_addr == horizontal_in_line_size)
                ready[wr_sel_n] <= 1'b1;
        end
    end

    // Catmull-Rom weights scaled to 512; f1 absorbs rounding so DC gain is exact
    logic signed [35:0] cd, cd2, cd3, c0n, c2n, c3n;
    logic signed [11:0] c1n;
    logic [9:0]         c0, c2, c3, c1;

    always_comb begin
        cd  = $signed({26'd0, dx_r});
        cd2 = cd * cd;
        cd3 = cd2 * cd;
        c3n = (cd2 <<< 10) - cd3 + 36'sd2097152;
        c0n = cd3 - (cd2 <<< 11) + (cd <<< 20) + 36'sd2097152;
        c2n = (cd2 <<< 12) + (cd <<< 20) - 36'sd3 * cd3 + 36'sd2097152;
        c0  = 10'(c0n >>> 22);
        c2  = 10'(c2n >>> 22);
        c3  = 10'(c3n >>> 22);
        c1n = 12'sd512 - $signed({2'b00, c2}) + $signed({2'b00, c0})
              + $signed({2'b00, c3});
        c1  = (c1n < 0) ? 10'd0 : c1n[9:0];
    end

    logic [9:0]         f0, f1, f2, f3;
    logic [WIDTH-1:0]   p0, p1, p2, p3;
    logic               rd_vld;
    logic [1:0]         rd_tap;
    logic [5:0]         pv, phs, pvs;
    logic [MW-1:0]      m0, m1, m2, m3;
    logic signed [SW-1:0] sum_c, sum_r;
    logic [WIDTH-1:0]   pixel_c;

    always_comb begin
        m0    = f0 * p0;
        m1    = f1 * p1;
        m2    = f2 * p2;
        m3    = f3 * p3;
        sum_c = $signed({2'b00, m1}) + $signed({2'b00, m2})
                - $signed({2'b00, m0}) - $signed({2'b00, m3}) + SW'(256);
        if (sum_r[SW-1])
            pixel_c = '0;
        else if (|sum_r[SW-2:WIDTH+9])
            pixel_c = '1;
        else
            pixel_c = sum_r[9 +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f0 <= '0; f1 <= '0; f2 <= '0; f3 <= '0;
            p0 <= '0; p1 <= '0; p2 <= '0; p3 <= '0;
            rd_vld <= 1'b0;
            rd_tap <= '0;
            pv     <= '0;
            phs    <= '0;
            pvs    <= '0;
            sum_r  <= '0;
            d_out  <= '0;
            dv_out <= 1'b0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
        end else begin
            f0 <= c0; f1 <= c1; f2 <= c2; f3 <= c3;
            rd_vld <= (state == TAP0) || (state == TAP1)
                      || (state == TAP2) || (state == TAP3);
            rd_tap <= tap;
            if (rd_vld) begin
                unique case (rd_tap)
                    2'd0: p0 <= rd_data;
                    2'd1: p1 <= rd_data;
                    2'd2: p2 <= rd_data;
                    default: p3 <= rd_data;
                endcase
            end
            pv    <= {pv[4:0], state == TAP0};
            phs   <= {phs[4:0], n == 16'd0};
            pvs   <= {pvs[4:0], line_vs && n == 16'd0};
            if (frame_restart)
                pv <= '0;
            sum_r  <= sum_c;
            dv_out <= pv[5];
            hs_out <= pv[5] & phs[5];
            vs_out <= pv[5] & pvs[5];
            if (pv[5])
                d_out <= pixel_c;
        end
    end
endmodule

// File: tb/tb_scaler_h.sv
// Directed bench for scaler_h: ramps, flats, clipping, abort, overflow, reset.
module tb_scaler_h;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] step, in_sz, out_sz;
    logic [11:0] d_in, d_out;
    logic        dv_in, hs_in, vs_in;
    logic        dv_out, hs_out, vs_out, overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    scaler_h dut (
        .clk(clk), .rst(rst),
        .horizontal_scale_step(step),
        .horizontal_in_line_size(in_sz),
        .horizontal_out_line_size(out_sz),
        .d_in(d_in), .dv_in(dv_in), .hs_in(hs_in), .vs_in(vs_in),
        .d_out(d_out), .dv_out(dv_out), .hs_out(hs_out), .vs_out(vs_out),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_px(input int d, input bit h, input bit v);
        d_in  = 12'(d);
        dv_in = 1'b1;
        hs_in = h;
        vs_in = v;
        @(negedge clk);
        dv_in = 1'b0;
        hs_in = 1'b0;
        vs_in = 1'b0;
    endtask

    task automatic wait_dv(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dv_out) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic expect_px(input string tag, input int d, input bit h,
                             input bit v, output int at);
        bit got;
        wait_dv(300, got);
        at = cyc;
        chk({tag, "_seen"}, 32'(got), 32'd1);
        chk({tag, "_d"}, 32'(d_out), 32'(d));
        chk({tag, "_hs"}, 32'(hs_out), 32'(h));
        chk({tag, "_vs"}, 32'(vs_out), 32'(v));
    endtask

    int exp3 [16] = '{0, 0, 0, 0, 0, 0, 0, 2048,
                      4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095};
    int line3 [8] = '{0, 0, 0, 0, 4095, 4095, 4095, 4095};

    initial begin
        int t0, at, prev;
        bit got;
        rst = 1'b1;
        d_in = '0; dv_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        step = 16'd4096; in_sz = 16'd7; out_sz = 16'd7;
        repeat (3) @(negedge clk);
        chk("rst_dv", 32'(dv_out), 0);
        chk("rst_d", 32'(d_out), 0);
        chk("rst_hs", 32'(hs_out), 0);
        chk("rst_vs", 32'(vs_out), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        @(negedge clk);

        // unity step ramp
        for (int k = 0; k < 8; k++) send_px(100 * k, k == 0, k == 0);
        t0 = cyc;
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            expect_px("t1", 100 * k, k == 0, k == 0, at);
            if (k == 0) chk("t1_lat", 32'(at - t0), 9);
            else chk("t1_gap", 32'(at - prev), 4);
            prev = at;
        end

        // 2x upscale of a flat line
        step = 16'd2048; out_sz = 16'd15;
        for (int k = 0; k < 8; k++) send_px(1000, k == 0, k == 0);
        for (int k = 0; k < 16; k++) begin
            expect_px("t2", 1000, k == 0, k == 0, at);
            if (k != 0) chk("t2_gap", 32'(at - prev), 4);
            prev = at;
        end

        // step edge: overshoot/undershoot clipping
        for (int k = 0; k < 8; k++) send_px(line3[k], k == 0, k == 0);
        for (int k = 0; k < 16; k++)
            expect_px("t3", exp3[k], k == 0, k == 0, at);

        // zero step repeats line[0]
        step = 16'd0; out_sz = 16'd3;
        for (int k = 0; k < 8; k++) send_px(500 + k, k == 0, k == 0);
        for (int k = 0; k < 4; k++)
            expect_px("t_step0", 500, k == 0, k == 0, at);

        // frame restart in the middle of a reader line
        step = 16'd4096; out_sz = 16'd7;
        for (int k = 0; k < 8; k++) send_px(100 * k, k == 0, k == 0);
        for (int k = 0; k < 3; k++)
            expect_px("t4a", 100 * k, k == 0, k == 0, at);
        for (int k = 0; k < 8; k++) send_px(50 + 10 * k, k == 0, k == 0);
        for (int k = 0; k < 8; k++)
            expect_px("t4b", 50 + 10 * k, k == 0, k == 0, at);

        // back-to-back lines too fast for the reader
        out_sz = 16'd63;
        chk("t5_ovf_init", 32'(overflow), 0);
        for (int k = 0; k < 16; k++)
            send_px(100 * (k % 8), (k % 8) == 0, k == 0);
        chk("t5_ovf_pre", 32'(overflow), 0);
        for (int k = 0; k < 8; k++) send_px(100 * k, k == 0, 1'b0);
        chk("t5_ovf_set", 32'(overflow), 1);
        repeat (20) @(negedge clk);
        chk("t5_ovf_sticky", 32'(overflow), 1);

        // asynchronous reset while pixels are streaming
        wait_dv(300, got);
        chk("t6_live", 32'(got), 1);
        chk("t6_d_pre", 32'(d_out != 12'd0), 1);
        rst = 1'b1;
        #1;
        chk("t6_dv", 32'(dv_out), 0);
        chk("t6_d", 32'(d_out), 0);
        chk("t6_hs", 32'(hs_out), 0);
        chk("t6_vs", 32'(vs_out), 0);
        chk("t6_ovf", 32'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        out_sz = 16'd7;
        @(negedge clk);
        for (int k = 0; k < 8; k++) send_px(3 + 11 * k, k == 0, k == 0);
        expect_px("t6_first", 3, 1'b1, 1'b1, at);
        expect_px("t6_second", 14, 1'b0, 1'b0, at);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
